// File: rtl/fft_peak_detect.sv
// L1 magnitude and per-frame peak search over a 32-bin FFT output stream.
// Each frame arrives as 32 real words, then 32 imaginary words, in bin order.
module fft_peak_detect #(
   parameter int N    = 16,
   parameter int Q    = 8,
   parameter int BINS = 32
) (
   input  logic         clk2,
   input  logic         rst,
   input  logic [N-1:0] in_data,
   input  logic         in_valid,
   input  logic         in_type,
   input  logic         in_done,
   output logic [N:0]   mag_out,
   output logic [4:0]   mag_index,
   output logic         mag_valid,
   output logic [N:0]   peak_mag,
   output logic [4:0]   peak_index,
   output logic         peak_valid,
   output logic         frame_err,
   output logic         busy
);

   if (Q >= N) begin : g_bad_q
      $error("fft_peak_detect: Q must be smaller than N");
   end

   typedef enum logic [1:0] {S_IDLE, S_COLLECT_RE, S_COLLECT_IM, S_REPORT} state_t;

   localparam logic [4:0] LAST_BIN = 5'(BINS - 1);

   state_t       state_q, state_d;
   logic [4:0]   cnt_q, cnt_d;
   logic         busy_q, busy_d;
   logic         err_q, err_d;
   logic [N:0]   mag_out_q, mag_out_d;
   logic [4:0]   mag_index_q, mag_index_d;
   logic         mag_valid_q, mag_valid_d;
   logic [N:0]   run_mag_q, run_mag_d;
   logic [4:0]   run_idx_q, run_idx_d;
   logic [N:0]   peak_mag_q, peak_mag_d;
   logic [4:0]   peak_idx_q, peak_idx_d;
   logic         peak_valid_q, peak_valid_d;
   logic         buf_we;

   logic [N-1:0] re_buf [BINS];

   // Sign-extend before negating so the most negative word has an exact magnitude.
   function automatic logic [N:0] abs_ext(input logic [N-1:0] v);
      logic [N:0] s;
      s = {v[N-1], v};
      return v[N-1] ? -s : s;
   endfunction

   logic [N+1:0] mag_sum;
   logic [N:0]   mag_sat;
   logic         new_peak;

   always_comb begin
      mag_sum  = {1'b0, abs_ext(re_buf[cnt_q])} + {1'b0, abs_ext(in_data)};
      mag_sat  = mag_sum[N+1] ? '1 : mag_sum[N:0];
      new_peak = (cnt_q == 5'd0) || (mag_sat > run_mag_q);
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d      = state_q;
      cnt_d        = cnt_q;
      busy_d       = busy_q;
      err_d        = 1'b0;
      buf_we       = 1'b0;
      mag_out_d    = mag_out_q;
      mag_index_d  = mag_index_q;
      mag_valid_d  = 1'b0;
      run_mag_d    = run_mag_q;
      run_idx_d    = run_idx_q;
      peak_mag_d   = peak_mag_q;
      peak_idx_d   = peak_idx_q;
      peak_valid_d = 1'b0;

      unique case (state_q)
         S_IDLE, S_REPORT: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = 5'd0;
            if (in_valid && !in_type) begin
               buf_we  = 1'b1;
               cnt_d   = 5'd1;
               busy_d  = 1'b1;
               state_d = S_COLLECT_RE;
            end else if (in_valid) begin
               err_d = 1'b1;
            end
         end
         S_COLLECT_RE: begin
            if (in_done || (in_valid && in_type)) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = 5'd0;
               state_d = S_IDLE;
            end else if (in_valid) begin
               buf_we = 1'b1;
               if (cnt_q == LAST_BIN) begin
                  cnt_d     = 5'd0;
                  run_mag_d = '0;
                  run_idx_d = 5'd0;
                  state_d   = S_COLLECT_IM;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         S_COLLECT_IM: begin
            if (in_done || (in_valid && !in_type)) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = 5'd0;
               state_d = S_IDLE;
            end else if (in_valid) begin
               mag_valid_d = 1'b1;
               mag_out_d   = mag_sat;
               mag_index_d = cnt_q;
               if (new_peak) begin
                  run_mag_d = mag_sat;
                  run_idx_d = cnt_q;
               end
               if (cnt_q == LAST_BIN) begin
                  peak_mag_d   = new_peak ? mag_sat : run_mag_q;
                  peak_idx_d   = new_peak ? cnt_q : run_idx_q;
                  peak_valid_d = 1'b1;
                  busy_d       = 1'b0;
                  cnt_d        = 5'd0;
                  state_d      = S_REPORT;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the sample buffer carries no reset; every entry is rewritten before it is read.
   always_ff @(posedge clk2) begin
      if (buf_we) re_buf[cnt_q] <= in_data;
   end

   always_ff @(posedge clk2) begin
      // NOTE: state registers use non-blocking assignments so all update together at the edge.
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 5'd0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         mag_out_q    <= '0;
         mag_index_q  <= 5'd0;
         mag_valid_q  <= 1'b0;
         run_mag_q    <= '0;
         run_idx_q    <= 5'd0;
         peak_mag_q   <= '0;
         peak_idx_q   <= 5'd0;
         peak_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         mag_out_q    <= mag_out_d;
         mag_index_q  <= mag_index_d;
         mag_valid_q  <= mag_valid_d;
         run_mag_q    <= run_mag_d;
         run_idx_q    <= run_idx_d;
         peak_mag_q   <= peak_mag_d;
         peak_idx_q   <= peak_idx_d;
         peak_valid_q <= peak_valid_d;
      end
   end

   assign mag_out    = mag_out_q;
   assign mag_index  = mag_index_q;
   assign mag_valid  = mag_valid_q;
   assign peak_mag   = peak_mag_q;
   assign peak_index = peak_idx_q;
   assign peak_valid = peak_valid_q;
   assign frame_err  = err_q;
   assign busy       = busy_q;

endmodule
